timer_dev: RTL and testbench

Memory-mapped programmable countdown timer that sources one hardware interrupt line for the CPU's coprocessor-0 interrupt logic. Software programs a preset value and a control word over the bus. The timer counts down every clock and raises a level interrupt on expiry, in one-shot or periodic mode. Its `irq` output drives one bit of the CP0 `HWInt[7:2]` input; software acknowledges by rewriting the control register from its exception handler.

---
 rtl/timer_dev_if.sv | 17 +
 rtl/timer_dev.sv | 167 ++++++++++++++++
 tb/tb_timer_dev.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_if.sv
// -----------------------------------------------------------------------------
// timer_dev_if
// Register bus between a CPU-side master and the timer_dev register file.
//   addr  word select (bus address bits [3:2])
//   we    write strobe, register selected by addr is written at the clock edge
//   din   write data
//   dout  combinational read data of the selected register
// -----------------------------------------------------------------------------
interface timer_dev_if;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;

   modport master (output addr, output we, output din, input dout);
   modport slave  (input addr, input we, input din, output dout);
endinterface : timer_dev_if

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
// Memory-mapped programmable countdown timer sourcing one level interrupt for
// the CP0 HWInt inputs. Software loads PRESET and CTRL; the timer reloads from
// PRESET, counts down once per clock and sets IP on expiry, either once
// (one-shot, EN auto-clears) or repeatedly (periodic).
//
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous reset, active low
//   bus  register bus (slave side): addr/we/din in, dout out
//        addr 0 = CTRL, 1 = PRESET, 2 = COUNT (ro), 3 = ID (ro)
//   irq  interrupt request, level, IP & IM
//
// CTRL: bit0 EN, bit1 MODE (1 = periodic), bit3 IM, bit4 IP (ro), others 0.
// -----------------------------------------------------------------------------
module timer_dev #(
   parameter logic [31:0] ID_VALUE = 32'h0054696d
) (
   input  logic        clk,
   input  logic        rst,
   timer_dev_if.slave  bus,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_ID     = 2'd3;

   state_t      r_state;
   logic        r_en;
   logic        r_mode;
   logic        r_im;
   logic        r_ip;
   logic [31:0] r_preset;
   logic [31:0] r_count;

   state_t      w_state_nxt;
   logic [31:0] w_count_nxt;
   logic        w_ip_set;
   logic        w_en_hw_clr;
   logic        w_ctrl_wr;
   logic        w_preset_wr;
   logic [31:0] w_rdata;

   assign w_ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
   assign w_preset_wr = bus.we && (bus.addr == ADDR_PRESET);

   // Next-state and counter datapath.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_ip_set    = 1'b0;
      w_en_hw_clr = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_en) begin
               w_state_nxt = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // EN dropped by software before the load: abandon without
            // touching COUNT.
            if (!r_en) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_count_nxt = r_preset;
               w_state_nxt = ST_CNT;
            end
         end

         ST_CNT: begin
            if (!r_en) begin
               w_state_nxt = ST_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               // COUNT of 0 or 1 both expire here, so PRESET=0 acts as 1 and
               // the counter saturates at 0 instead of wrapping.
               w_count_nxt = 32'd0;
               w_ip_set    = 1'b1;
               w_state_nxt = ST_INT;
            end
         end

         ST_INT: begin
            if (!r_mode) begin
               w_en_hw_clr = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: reset is sampled only on the clock edge (synchronous), so it sits
   // inside the clocked block and is not in the sensitivity list.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_en     <= 1'b0;
         r_mode   <= 1'b0;
         r_im     <= 1'b0;
         r_ip     <= 1'b0;
         r_preset <= 32'd0;
         r_count  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;

         if (w_preset_wr) begin
            r_preset <= bus.din;
         end

         // A software CTRL write overrides the one-shot auto-clear of EN.
         if (w_ctrl_wr) begin
            r_en   <= bus.din[0];
            r_mode <= bus.din[1];
            r_im   <= bus.din[3];
         end else if (w_en_hw_clr) begin
            r_en <= 1'b0;
         end

         // Expiry beats a same-edge acknowledge so no interrupt is lost.
         if (w_ip_set) begin
            r_ip <= 1'b1;
         end else if (w_ctrl_wr) begin
            r_ip <= 1'b0;
         end
      end
   end

   // Zero-latency register read.
   always_comb begin
      w_rdata = 32'd0;
      case (bus.addr)
         ADDR_CTRL:   w_rdata = {27'd0, r_ip, r_im, 1'b0, r_mode, r_en};
         ADDR_PRESET: w_rdata = r_preset;
         ADDR_COUNT:  w_rdata = r_count;
         ADDR_ID:     w_rdata = ID_VALUE;
         default:     w_rdata = 32'd0;
      endcase
   end

   assign bus.dout = w_rdata;
   assign irq      = r_ip & r_im;

endmodule : timer_dev

// File: tb/tb_timer_dev.sv
// -----------------------------------------------------------------------------
// tb_timer_dev
// Self-checking bench for timer_dev. Stimulus pushes expected register reads
// and irq levels, tagged with the clock edge after which they must hold, into
// a scoreboard queue; after every edge the due entries are popped and compared
// against the DUT.
// -----------------------------------------------------------------------------
module tb_timer_dev;

   localparam logic [31:0] ID_VAL = 32'h0054696d;

   typedef struct {
      string       tag;
      int unsigned at;
      bit          is_irq;
      logic [1:0]  a;
      logic [31:0] v;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        irq;
   int unsigned edge_no;
   int unsigned t0;
   int          n_checks;
   int          n_fail;
   exp_t        sb_q[$];

   timer_dev_if bus ();

   timer_dev #(.ID_VALUE(ID_VAL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .irq (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, obs, exp, edge_no);
      end
   endtask

   task automatic exp_rd(input string tag, input int unsigned rel, input logic [1:0] a,
                         input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.at = t0 + rel; e.is_irq = 1'b0; e.a = a; e.v = v;
      sb_q.push_back(e);
   endtask

   task automatic exp_irq(input string tag, input int unsigned rel, input logic v);
      exp_t e;
      e.tag = tag; e.at = t0 + rel; e.is_irq = 1'b1; e.a = 2'd0; e.v = {31'd0, v};
      sb_q.push_back(e);
   endtask

   // Pop every entry due at the current edge and compare it.
   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].at <= edge_no) begin
         e = sb_q.pop_front();
         if (e.at < edge_no) begin
            check({e.tag, "_late"}, edge_no, e.at);
         end else if (e.is_irq) begin
            check(e.tag, {31'd0, irq}, e.v);
         end else begin
            bus.addr = e.a;
            #1;
            check(e.tag, bus.dout, e.v);
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drain();
      end
   endtask

   // Single-cycle register write; t0 becomes the edge that performed it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr = a;
      bus.din  = d;
      bus.we   = 1'b1;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      t0     = edge_no;
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      t0       = 0;
      rst      = 1'b0;
      bus.we   = 1'b0;
      bus.addr = 2'd0;
      bus.din  = 32'd0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      t0 = edge_no;
      exp_rd("rst_ctrl", 0, 2'd0, 32'd0);
      exp_rd("rst_preset", 0, 2'd1, 32'd0);
      exp_rd("rst_count", 0, 2'd2, 32'd0);
      exp_rd("rst_id", 0, 2'd3, ID_VAL);
      exp_irq("rst_irq", 0, 1'b0);
      drain();
      rst = 1'b1;
      step(1);

      // One-shot, PRESET=5, EN+IM.
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      for (int i = 2; i <= 6; i++) exp_rd("os_count", i, 2'd2, 32'(7 - i));
      exp_irq("os_irq_lo", 6, 1'b0);
      exp_irq("os_irq_hi", 7, 1'b1);
      exp_rd("os_ctrl", 8, 2'd0, 32'h18);
      exp_irq("os_irq_hold", 8, 1'b1);
      exp_rd("os_count_end", 8, 2'd2, 32'd0);
      step(8);
      wr(2'd0, 32'h8);
      exp_irq("os_ack_irq", 0, 1'b0);
      exp_rd("os_ack_ctrl", 0, 2'd0, 32'h08);
      drain();

      // Periodic, PRESET=3.
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      exp_irq("per_lo", 4, 1'b0);
      exp_irq("per_hi", 5, 1'b1);
      exp_rd("per_ctrl", 5, 2'd0, 32'h1B);
      step(5);
      wr(2'd0, 32'hB);
      exp_irq("per_ack", 0, 1'b0);
      exp_rd("per_ack_ctrl", 0, 2'd0, 32'h0B);
      drain();
      exp_irq("per_lo2", 3, 1'b0);
      exp_irq("per_hi2", 4, 1'b1);
      step(4);

      // Ack coinciding with the next expiry edge: the set wins.
      wr(2'd0, 32'hB);
      exp_irq("race_pre_ack", 0, 1'b0);
      drain();
      exp_rd("race_cnt", 3, 2'd2, 32'd1);
      step(3);
      wr(2'd0, 32'hB);
      exp_irq("race_irq", 0, 1'b1);
      exp_rd("race_ctrl", 0, 2'd0, 32'h1B);
      drain();
      exp_irq("race_hold", 1, 1'b1);
      step(1);
      wr(2'd0, 32'h0);
      exp_irq("race_off", 0, 1'b0);
      drain();
      step(2);

      // Stop mid-count at COUNT=7, then restart reloads from PRESET.
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      exp_rd("stop_cnt10", 2, 2'd2, 32'd10);
      step(4);
      wr(2'd0, 32'h0);
      exp_rd("stop_cnt7", 0, 2'd2, 32'd7);
      drain();
      exp_rd("stop_hold", 1, 2'd2, 32'd7);
      exp_rd("stop_hold4", 4, 2'd2, 32'd7);
      exp_irq("stop_irq", 4, 1'b0);
      exp_rd("stop_ctrl", 4, 2'd0, 32'h0);
      step(4);
      wr(2'd0, 32'h1);
      exp_rd("resume_wait", 1, 2'd2, 32'd7);
      exp_rd("resume_load", 2, 2'd2, 32'd10);
      exp_rd("resume_dec", 3, 2'd2, 32'd9);
      step(3);
      wr(2'd0, 32'h0);
      step(2);

      // PRESET=0 with IM=0: expiry after t+3, IP visible, irq masked.
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      exp_rd("p0_cnt", 2, 2'd2, 32'd0);
      exp_rd("p0_ctrl_pre", 2, 2'd0, 32'h01);
      exp_rd("p0_ip", 3, 2'd0, 32'h11);
      exp_irq("p0_masked", 3, 1'b0);
      exp_rd("p0_idle", 4, 2'd0, 32'h10);
      exp_irq("p0_masked2", 4, 1'b0);
      step(4);
      wr(2'd0, 32'h8);
      exp_rd("p0_ack_ctrl", 0, 2'd0, 32'h08);
      exp_irq("p0_ack_irq", 0, 1'b0);
      drain();
      exp_irq("p0_ack_irq2", 2, 1'b0);
      step(2);

      // Writes to read-only registers are ignored.
      wr(2'd2, 32'hDEADBEEF);
      wr(2'd3, 32'h12345678);
      exp_rd("ro_count", 0, 2'd2, 32'd0);
      exp_rd("ro_id", 0, 2'd3, ID_VAL);
      drain();

      // Reset in the middle of a count clears everything.
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h9);
      exp_rd("mr_cnt", 5, 2'd2, 32'd17);
      step(5);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      t0  = edge_no;
      exp_rd("mr_ctrl", 0, 2'd0, 32'd0);
      exp_rd("mr_preset", 0, 2'd1, 32'd0);
      exp_rd("mr_count", 0, 2'd2, 32'd0);
      exp_irq("mr_irq", 0, 1'b0);
      drain();
      exp_rd("mr_idle", 2, 2'd2, 32'd0);
      exp_irq("mr_irq2", 2, 1'b0);
      step(2);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_timer_dev
